// File: rtl/btn_debounce_io.sv
// btn_debounce_io
//   Debounced push-button peripheral on the CPU bus. Raw buttons are brought into the
//   clock domain through a two-flop synchroniser, then each bit is filtered by its own
//   four-state FSM. The block exposes the stable levels, sticky press flags (W1C) and an
//   8-bit wrapping press counter as memory-mapped read data.
//
// Ports
//   clk      CPU clock
//   rst_n    asynchronous reset, active low
//   btn_raw  raw asynchronous button pins, 1 = pressed
//   addr     byte offset inside the button window, decoded on addr[3:2]
//   we       write strobe for this window
//   wdata    write data (0x4: W1C mask for press flags, 0x8: any value clears counter)
//   rdata    read data, combinational from addr and registered state
//   btn_lvl  debounced levels
//
// Register map (addr[3:2])
//   0x0  {0, btn_lvl}
//   0x4  {0, press flags}
//   0x8  {24'h0, press counter}
//   0xC  32'h0

module btn_debounce_io #(
    parameter int unsigned N_BTN     = 5,
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [3:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [N_BTN-1:0] btn_lvl
);

    typedef enum logic [1:0] {
        StRel,
        StPWait,
        StHeld,
        StRWait
    } db_state_e;

    // The counter value seen on the cycle whose sample completes the qualification window.
    // Entering a wait state already counts one sample, so the final sample arrives with
    // cnt == DB_CYCLES-1.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] flags_q;
    logic [N_BTN-1:0] flags_d;
    logic [7:0]       pcnt_q;
    logic [7:0]       pcnt_d;
    logic [7:0]       press_cnt;
    logic             flag_clr;
    logic             cnt_clr;

    // Low address bits and upper write-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:N_BTN]};

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce FSM
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        db_state_e        state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             lvl_q;

        // Press pulse is high in the cycle whose edge moves the FSM into StHeld, so flags
        // and the counter update on the same edge as btn_lvl rises.
        assign press[i]   = (state_q == StPWait) && sync2_q[i] && (cnt_q == CntLast);
        assign btn_lvl[i] = lvl_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StRel;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StRel: begin
                        if (sync2_q[i]) begin
                            cnt_q   <= CntOne;
                            state_q <= StPWait;
                        end
                    end
                    StPWait: begin
                        if (!sync2_q[i]) begin
                            cnt_q   <= '0;
                            state_q <= StRel;
                        end else if (cnt_q == CntLast) begin
                            cnt_q   <= '0;
                            state_q <= StHeld;
                            lvl_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                    StHeld: begin
                        if (!sync2_q[i]) begin
                            cnt_q   <= CntOne;
                            state_q <= StRWait;
                        end
                    end
                    StRWait: begin
                        if (sync2_q[i]) begin
                            cnt_q   <= '0;
                            state_q <= StHeld;
                        end else if (cnt_q == CntLast) begin
                            cnt_q   <= '0;
                            state_q <= StRel;
                            lvl_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= StRel;
                        lvl_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Press flags and press counter
    // ------------------------------------------------------------------
    assign flag_clr = we && (addr[3:2] == 2'b01);
    assign cnt_clr  = we && (addr[3:2] == 2'b10);

    always_comb begin
        press_cnt = 8'h00;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            press_cnt = press_cnt + {7'b0, press[i]};
        end
    end

    // Set after clear: a press in the W1C cycle keeps its flag.
    assign flags_d = (flags_q & ~(flag_clr ? wdata[N_BTN-1:0] : '0)) | press;
    // A press in the clearing cycle is not lost: the counter loads the popcount.
    assign pcnt_d  = (cnt_clr ? 8'h00 : pcnt_q) + press_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            pcnt_q  <= 8'h00;
        end else begin
            flags_q <= flags_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 32'h0;
        unique case (addr[3:2])
            2'b00:   rdata[N_BTN-1:0] = btn_lvl;
            2'b01:   rdata[N_BTN-1:0] = flags_q;
            2'b10:   rdata[7:0]       = pcnt_q;
            default: rdata            = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_btn_debounce_io.sv
// Self-checking bench for btn_debounce_io with DB_CYCLES=4, CNT_W=3.
// Reference model: a button's level flips once DB consecutive synchronised samples
// disagree with it; the synchroniser is a two-deep history of raw inputs.

module tb_btn_debounce_io;

    localparam int NB = 5;
    localparam int DB = 4;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [3:0]    addr;
    logic          we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [NB-1:0] btn_lvl;

    int n_chk  = 0;
    int n_fail = 0;

    btn_debounce_io #(
        .N_BTN     (NB),
        .DB_CYCLES (DB),
        .CNT_W     (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .btn_lvl (btn_lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int            run [NB];
    logic [NB-1:0] m_lvl;
    logic [NB-1:0] m_flags;
    logic [7:0]    m_cnt;
    logic [NB-1:0] hist1;
    logic [NB-1:0] hist2;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) run[i] = 0;
        m_lvl   = '0;
        m_flags = '0;
        m_cnt   = 8'h00;
        hist1   = '0;
        hist2   = '0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        case (a[3:2])
            2'd0:    return {27'h0, m_lvl};
            2'd1:    return {27'h0, m_flags};
            2'd2:    return {24'h0, m_cnt};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge with the inputs currently driven, then compare btn_lvl.
    task automatic cycle();
        logic [NB-1:0] s;
        logic [NB-1:0] pressed;
        int            np;
        s       = hist2;
        pressed = '0;
        np      = 0;
        for (int i = 0; i < NB; i++) begin
            if (s[i] != m_lvl[i]) run[i]++;
            else                  run[i] = 0;
            if (run[i] == DB) begin
                m_lvl[i] = ~m_lvl[i];
                run[i]   = 0;
                if (m_lvl[i]) begin
                    pressed[i] = 1'b1;
                    np++;
                end
            end
        end
        if (we && addr[3:2] == 2'd1) m_flags = m_flags & ~wdata[NB-1:0];
        m_flags = m_flags | pressed;
        if (we && addr[3:2] == 2'd2) m_cnt = 8'h00;
        m_cnt = m_cnt + 8'(np);
        hist2 = hist1;
        hist1 = btn_raw;
        @(posedge clk);
        #1;
        chk("lvl_model", {27'h0, btn_lvl}, {27'h0, m_lvl});
    endtask

    task automatic rd(input logic [3:0] a, input string name);
        addr = a;
        #1;
        chk(name, rdata, exp_rd(a));
    endtask

    task automatic rd_const(input logic [3:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        we    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // One full press/release of btn 4: 4 samples high, 4 samples low.
    task automatic press_btn4();
        btn_raw = 5'h10;
        repeat (4) cycle();
        btn_raw = 5'h00;
        repeat (4) cycle();
    endtask

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] lvl;
        logic [31:0]   flags;
        logic [31:0]   cnt;
    } vec_t;

    vec_t vecs [8];
    int   hold [NB];
    int   hi_cnt;
    int   first_hi;

    initial begin
        // Edges counted from reset release with all buttons held.
        for (int k = 0; k < 8; k++) begin
            vecs[k].raw   = 5'h1F;
            vecs[k].lvl   = (k >= 5) ? 5'h1F : 5'h00;
            vecs[k].flags = (k >= 5) ? 32'h1F : 32'h0;
            vecs[k].cnt   = (k >= 5) ? 32'h5 : 32'h0;
        end

        rst_n   = 1'b0;
        btn_raw = '0;
        addr    = 4'h0;
        we      = 1'b0;
        wdata   = 32'h0;

        // ---- 1. reset value and first qualification ----
        btn_raw = 5'h1F;
        do_reset();
        rd_const(4'h0, 32'h0, "t1_rd0_reset");
        rd_const(4'h4, 32'h0, "t1_rd4_reset");
        rd_const(4'h8, 32'h0, "t1_rd8_reset");
        rd_const(4'hC, 32'h0, "t1_rdC_reset");
        for (int k = 0; k < 8; k++) begin
            btn_raw = vecs[k].raw;
            cycle();
            chk("t1_lvl", {27'h0, btn_lvl}, {27'h0, vecs[k].lvl});
            rd_const(4'h4, vecs[k].flags, "t1_flags");
            rd_const(4'h8, vecs[k].cnt, "t1_cnt");
            rd_const(4'hC, 32'h0, "t1_rdC");
        end

        // ---- 2. bounce rejection ----
        btn_raw = '0;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            btn_raw = ((k % 4) == 3) ? 5'h00 : 5'h01;
            cycle();
            chk("t2_lvl0", {31'h0, btn_lvl[0]}, 32'h0);
        end
        btn_raw = '0;
        rd_const(4'h4, 32'h0, "t2_flags");
        rd_const(4'h8, 32'h0, "t2_cnt");

        // ---- 3. clean press/release of btn 2 ----
        do_reset();
        hi_cnt   = 0;
        first_hi = -1;
        for (int k = 1; k <= 24; k++) begin
            btn_raw = (k <= 10) ? 5'h04 : 5'h00;
            cycle();
            addr = 4'h0;
            #1;
            if (rdata == 32'h4) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = k;
            end
        end
        chk("t3_hi_window", 32'(hi_cnt), 32'd10);
        chk("t3_first_hi", 32'(first_hi), 32'(2 + DB));
        rd_const(4'h0, 32'h0, "t3_released");
        rd_const(4'h4, 32'h4, "t3_flags");
        rd_const(4'h8, 32'h1, "t3_cnt");
        addr  = 4'h4;
        wdata = 32'h4;
        we    = 1'b1;
        #1;
        chk("t3_preclear_read", rdata, 32'h4);
        cycle();
        we = 1'b0;
        rd_const(4'h4, 32'h0, "t3_w1c");
        rd_const(4'h8, 32'h1, "t3_cnt_kept");

        // ---- 4. collisions ----
        do_reset();
        btn_raw = 5'h02;
        repeat (5) cycle();
        addr  = 4'h4;
        wdata = 32'h2;
        we    = 1'b1;
        cycle();
        we = 1'b0;
        rd_const(4'h4, 32'h2, "t4_set_wins");
        rd_const(4'h8, 32'h1, "t4_cnt1");
        btn_raw = 5'h0B;
        repeat (6) cycle();
        rd_const(4'h8, 32'h3, "t4_cnt_plus2");
        rd_const(4'h4, 32'hB, "t4_flags");
        rd(4'h0, "t4_lvl_rd");

        // ---- 5. counter wrap ----
        btn_raw = '0;
        do_reset();
        for (int k = 0; k < 256; k++) press_btn4();
        rd_const(4'h8, 32'h0, "t5_wrap");
        press_btn4();
        rd_const(4'h8, 32'h1, "t5_wrap_plus1");
        btn_raw = 5'h10;
        repeat (4) cycle();
        btn_raw = 5'h00;
        cycle();
        addr  = 4'h8;
        wdata = 32'hDEAD_BEEF;
        we    = 1'b1;
        cycle();
        we = 1'b0;
        rd_const(4'h8, 32'h1, "t5_clear_with_press");
        repeat (4) cycle();

        // ---- 6. reset during release qualification ----
        do_reset();
        btn_raw = 5'h1F;
        repeat (6) cycle();
        rd_const(4'h0, 32'h1F, "t6_held");
        btn_raw = 5'h00;
        repeat (3) cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_lvl", {27'h0, btn_lvl}, 32'h0);
        rd_const(4'h4, 32'h0, "t6_flags_rst");
        rd_const(4'h8, 32'h0, "t6_cnt_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) cycle();
        rd_const(4'h4, 32'h0, "t6_no_spurious_flag");
        rd_const(4'h8, 32'h0, "t6_no_spurious_cnt");

        // ---- random stimulus against the model ----
        do_reset();
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = 1'($urandom_range(0, 1));
                    hold[i]    = $urandom_range(1, 9);
                end
                hold[i]--;
            end
            we    = ($urandom_range(0, 5) == 0);
            wdata = $urandom();
            addr  = 4'($urandom_range(0, 15));
            #1;
            if (we) chk("rnd_preclear_read", rdata, exp_rd(addr));
            cycle();
            we = 1'b0;
            rd(4'h0, "rnd_rd0");
            rd(4'h4, "rnd_rd4");
            rd(4'h8, "rnd_rd8");
            rd(4'hC, "rnd_rdC");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
